// File: rtl/poly_synth_core.sv
// poly_synth_core: polyphonic square-wave synth voice bank.
// Each voice has its own oscillator and ADSR envelope. All envelopes share
// one set of rate and sustain settings. The voices are summed through a
// single time-multiplexed 8x8 multiplier into one 16-bit sample per tick.
module poly_synth_core #(
  parameter int VOICES     = 4,
  parameter int SAMPLE_DIV = 512,
  parameter int ADSR_DIV   = 512,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [VOICES-1:0]         trig,
  input  logic [7:0]                adsr_ai,
  input  logic [7:0]                adsr_di,
  input  logic [7:0]                adsr_s,
  input  logic [7:0]                adsr_ri,
  input  logic [VOICES*CNT_W-1:0]   osc_count,
  output logic [15:0]               sample,
  output logic                      sample_valid,
  output logic [VOICES-1:0]         active
);

  localparam int SH     = (VOICES > 1) ? $clog2(VOICES) : 0;
  localparam int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int ACC_W  = 16 + SH;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ADIV_W = (ADSR_DIV > 1) ? $clog2(ADSR_DIV) : 1;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  logic [DIV_W-1:0]  div_cnt;
  logic [ADIV_W-1:0] env_div;
  logic              sample_tick;
  logic              env_tick;

  logic [CNT_W-1:0]  osc_cnt [VOICES];
  logic [VOICES-1:0] phase;

  env_state_t        env_state  [VOICES];
  logic [7:0]        env_val    [VOICES];
  env_state_t        step_state [VOICES];
  logic [7:0]        step_env   [VOICES];

  logic [7:0]        ai_eff;
  logic [7:0]        di_eff;
  logic [7:0]        ri_eff;

  logic              mix_busy;
  logic [IDX_W-1:0]  mix_idx;
  logic [ACC_W-1:0]  acc;
  logic [7:0]        mul_osc;
  logic [7:0]        mul_env;
  logic [15:0]       product;
  logic [ACC_W-1:0]  acc_sum;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'h00;
  endfunction

  assign sample_tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign env_tick    = sample_tick && (env_div == ADIV_W'(ADSR_DIV - 1));

  // A zero rate would freeze an envelope in place, so it is bumped to 1.
  assign ai_eff = (adsr_ai == 8'h00) ? 8'h01 : adsr_ai;
  assign di_eff = (adsr_di == 8'h00) ? 8'h01 : adsr_di;
  assign ri_eff = (adsr_ri == 8'h00) ? 8'h01 : adsr_ri;

  // Sample and envelope prescalers; both are plain enables, never clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      env_div <= '0;
    end else begin
      if (sample_tick) begin
        div_cnt <= '0;
        if (env_div == ADIV_W'(ADSR_DIV - 1)) begin
          env_div <= '0;
        end else begin
          env_div <= env_div + ADIV_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Per-voice oscillators: a count that reaches or passes its limit wraps to 0 and flips the phase.
  always_ff @(posedge clk) begin
    for (int i = 0; i < VOICES; i++) begin
      if (rst) begin
        osc_cnt[i] <= '0;
        phase[i]   <= 1'b0;
      end else if (sample_tick) begin
        if (osc_cnt[i] >= osc_count[i*CNT_W +: CNT_W]) begin
          osc_cnt[i] <= '0;
          phase[i]   <= ~phase[i];
        end else begin
          osc_cnt[i] <= osc_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Envelope next-state: a tick that enters a new state also applies that state's step,
  // and a released gate overrides every other transition.
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      step_state[i] = env_state[i];
      step_env[i]   = env_val[i];
      if (trig[i]) begin
        case (env_state[i])
          ENV_DECAY: begin
            step_env[i]   = (sat_sub(env_val[i], di_eff) > adsr_s) ? sat_sub(env_val[i], di_eff) : adsr_s;
            step_state[i] = (step_env[i] == adsr_s) ? ENV_SUSTAIN : ENV_DECAY;
          end
          ENV_SUSTAIN: begin
            step_env[i]   = adsr_s;
            step_state[i] = ENV_SUSTAIN;
          end
          default: begin
            step_env[i] = sat_add(env_val[i], ai_eff);
            if (step_env[i] == 8'hFF) begin
              step_state[i] = (adsr_s == 8'hFF) ? ENV_SUSTAIN : ENV_DECAY;
            end else begin
              step_state[i] = ENV_ATTACK;
            end
          end
        endcase
      end else if (env_state[i] == ENV_IDLE) begin
        step_env[i]   = 8'h00;
        step_state[i] = ENV_IDLE;
      end else begin
        step_env[i]   = sat_sub(env_val[i], ri_eff);
        step_state[i] = (step_env[i] == 8'h00) ? ENV_IDLE : ENV_RELEASE;
      end
    end
  end

  // Envelope registers and the active flags advance only on envelope ticks.
  always_ff @(posedge clk) begin
    for (int i = 0; i < VOICES; i++) begin
      if (rst) begin
        env_state[i] <= ENV_IDLE;
        env_val[i]   <= 8'h00;
        active[i]    <= 1'b0;
      end else if (env_tick) begin
        env_state[i] <= step_state[i];
        env_val[i]   <= step_env[i];
        active[i]    <= (step_state[i] != ENV_IDLE);
      end
    end
  end

  assign mul_osc = phase[mix_idx] ? 8'hFF : 8'h00;
  assign mul_env = env_val[mix_idx];
  assign product = {8'h00, mul_osc} * {8'h00, mul_env};
  assign acc_sum = acc + ACC_W'(product);

  // Mixer: one voice per cycle after each sample tick, then publish the scaled sum with a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_busy     <= 1'b0;
      mix_idx      <= '0;
      acc          <= '0;
      sample       <= 16'h0000;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick) begin
        mix_busy <= 1'b1;
        mix_idx  <= '0;
        acc      <= '0;
      end else if (mix_busy) begin
        acc <= acc_sum;
        if (mix_idx == IDX_W'(VOICES - 1)) begin
          mix_busy     <= 1'b0;
          sample       <= acc_sum[SH +: 16];
          sample_valid <= 1'b1;
        end else begin
          mix_idx <= mix_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/poly_synth_core.md
# poly_synth_core

Single-clock, parametrised polyphonic successor to the mono `synth` datapath. It generates VOICES independent square-wave oscillators, each shaped by its own ADSR envelope. All envelopes share one set of rate/sustain settings. Voices are mixed through one time-multiplexed 8x8 multiplier into a 16-bit sample with a valid strobe, which feeds the existing filter/DAC stage. All rate division uses clock enables derived from `clk`; there are no generated clocks.

## Interface
- VOICES, 4: number of voices; power of two, 1..16.
- SAMPLE_DIV, 512: `clk` cycles per sample tick; must be >= VOICES+2.
- ADSR_DIV, 512: sample ticks per envelope tick; >= 1.
- CNT_W, 32: oscillator counter width.

- clk  in  1  system clock, 20.48 MHz nominal.
- rst  in  1  synchronous, active-high reset.
- trig  in  VOICES  per-voice gate, level-sensitive; bit i belongs to voice i.
- adsr_ai, adsr_di, adsr_s, adsr_ri  in  8 each  attack step, decay step, sustain level, release step; shared by all voices.
- osc_count  in  VOICES*CNT_W  per-voice half-period in sample ticks; voice i uses [i*CNT_W +: CNT_W].
- sample  out  16  mixed output; holds its value between strobes.
- sample_valid  out  1  one-cycle strobe when `sample` updates.
- active  out  VOICES  bit i high while voice i's envelope state is not IDLE.

## Operation
- **Prescalers**
  - Sample prescaler counts 0..SAMPLE_DIV-1. The sample tick fires in the cycle the count equals SAMPLE_DIV-1.
  - Envelope prescaler counts sample ticks. The envelope tick coincides with every ADSR_DIV-th sample tick.
- **Oscillator (per voice), on a sample tick**
  - If cnt >= osc_count[i]: cnt <= 0 and the phase toggles. Otherwise cnt <= cnt+1.
  - osc_count = 0 toggles the phase on every tick.
  - Output is 8'hFF when phase is high, 8'h00 when low. Phase resets low.
- **Envelope (per voice), on an envelope tick only**
  - States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. The envelope value `env` is 8 bits.
  - A rate input of 0 is treated as 1, so no state can lock up.
  - IDLE: env = 0. trig high -> ATTACK.
  - ATTACK: env = min(255, env+ai). At 255 -> DECAY.
  - DECAY: env = max(s, env-di). Reaching s -> SUSTAIN. If s = 255, go straight to SUSTAIN.
  - SUSTAIN: env <= s each tick, so it tracks live changes to `s`.
  - trig low in ATTACK, DECAY or SUSTAIN -> RELEASE. This takes priority over every other transition in the same tick.
  - RELEASE: env = max(0, env-ri). At 0 -> IDLE. trig high in RELEASE -> ATTACK, starting from the current env (retrigger, no jump to 0).
  - All arithmetic saturates. No wrap-around is permitted.
- **Mixing**
  - Triggered by each sample tick. Oscillator and envelope updates from that tick are visible to the mix.
  - Over VOICES consecutive cycles, voice k's 16-bit product osc_k*env_k is added into an accumulator of width 16+log2(VOICES). The accumulator clears at the start of each mix.
  - In the next cycle: sample <= acc >> log2(VOICES) and sample_valid is pulsed. VOICES=1 means no shift.
- **Reset**
  - rst clears all counters, phases and accumulators, and forces every envelope to IDLE with env 0.
  - Outputs reset to sample = 0, sample_valid = 0, active = 0.
  - rst during an in-flight mix aborts it; no strobe is produced.
  - rst has priority over every tick.

## Timing
- With tick in cycle T, sample_valid is high in cycle T+VOICES+1 and low otherwise. The strobe period is exactly SAMPLE_DIV cycles.
- After rst deasserts, the first sample tick is in cycle SAMPLE_DIV-1, counting cycle 0 as the first cycle with rst low.
- `active` and envelope state update in the cycle after the envelope tick.
- trig and config inputs are sampled only on ticks. Changes between ticks have no effect until the next tick.
- osc_count changes take effect at the next compare. A count already above the new limit wraps to 0 on that tick.

## Test plan
Default setup for scenarios 1-4: VOICES=2, SAMPLE_DIV=8, ADSR_DIV=1, CNT_W=8.
1. **Reset values.** Hold rst 3 cycles -> sample=0, sample_valid=0, active=0. Release -> first sample_valid in cycle 10, then every 8 cycles.
2. **Attack to full scale.** trig=01, ai=255, osc_count[0]=0 -> first strobe sample=16'h7F00 (0xFF*0xFF=0xFE01, >>1). Second strobe 16'h0000 (phase low). active=01.
3. **Decay, sustain, release.** ai=255, di=64, s=128, ri=32, trig held -> voice-0 env sequence 255, 191, 128, 128. Drop trig -> env 96, 64, 32, 0. Then IDLE and active[0]=0.
4. **Retrigger and two-voice mix.**
   - Retrigger: raise trig during RELEASE at env=64, ai=16 -> env 80, 96, ... with no reset to 0.
   - Two voices: both phases high, env=255 -> sample=16'hFE01.
5. **Reset mid-mix.** Assert rst in cycle T+1 after a tick -> no sample_valid for that tick, sample reads 0.
6. **Boundary values.** Rates ai=di=ri=0 -> envelope steps by 1 per tick. osc_count lowered below the running count -> phase toggles on the next tick.
